// File: rtl/monopulse_pkg.sv
// Shared types and constants for the monopulse ratio engine.
// MONOPULSE_SIGNED_EN selects signed output in the top; the package serves both builds.
package monopulse_pkg;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    // Upper bound for saturation constants; callers truncate to DATA_SIZE.
    localparam int MAX_DATA_SIZE = 256;

    function automatic int iter_count(input int data_size, input int frac_bits);
        return data_size + frac_bits;
    endfunction

    function automatic logic [MAX_DATA_SIZE-1:0] sat_max(input int data_size, input bit is_signed);
        logic [MAX_DATA_SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_SIZE; i++)
            if (i < data_size - (is_signed ? 1 : 0)) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/monopulse_divider.sv
// One channel's restoring divider: (dividend << FRAC_BITS) / divisor, one quotient bit per step.
// Quotient and overflow are presented from the next-step value so the caller can register on the last step.
module monopulse_divider #(
    parameter int DATA_SIZE = 64,
    parameter int FRAC_BITS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [DATA_SIZE-1:0] i_dividend,
    input  logic [DATA_SIZE-1:0] i_divisor,
    output logic [DATA_SIZE-1:0] o_quotient,
    output logic                 o_overflow
);
    localparam int QW = DATA_SIZE + FRAC_BITS;

    logic [DATA_SIZE-1:0] rem_q, rem_next, div_q;
    logic [DATA_SIZE:0]   rem_shift;
    logic [QW-1:0]        quo_q, quo_next;

    // Remainder stays below the divisor, so it fits DATA_SIZE bits after subtraction.
    always_comb begin
        rem_shift = {rem_q, quo_q[QW-1]};
        if (rem_shift >= {1'b0, div_q}) begin
            rem_next = DATA_SIZE'(rem_shift - {1'b0, div_q});
            quo_next = {quo_q[QW-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[DATA_SIZE-1:0];
            quo_next = {quo_q[QW-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (i_load) begin
            rem_q <= '0;
            quo_q <= QW'(i_dividend) << FRAC_BITS;
            div_q <= i_divisor;
        end else if (i_step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

    assign o_quotient = quo_next[DATA_SIZE-1:0];

    generate
        if (FRAC_BITS > 0) begin : g_ovf
            assign o_overflow = |quo_next[QW-1:DATA_SIZE];
        end else begin : g_no_ovf
            assign o_overflow = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/monopulse_ratio.sv
// Multi-channel |err|/|ref| (or signed err/ref) engine with fixed DATA_SIZE+FRAC_BITS latency.
// Define MONOPULSE_SIGNED_EN for two's-complement output; default build is unsigned magnitude.
module monopulse_ratio
    import monopulse_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int FRAC_BITS  = 16,
    parameter int N_CHANNELS = 2
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DATA_SIZE-1:0]             i_reference,
    input  logic [N_CHANNELS*DATA_SIZE-1:0]  i_error,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [N_CHANNELS*DATA_SIZE-1:0]  o_relation,
    output logic [N_CHANNELS-1:0]            o_div_zero
);
    localparam int ITER = iter_count(DATA_SIZE, FRAC_BITS);
    localparam int CW   = $clog2(ITER + 1);
`ifdef MONOPULSE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam logic [DATA_SIZE-1:0] SAT = DATA_SIZE'(sat_max(DATA_SIZE, SIGNED_EN));

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            ref_zero;
    logic            accept, stepping;
    logic [DATA_SIZE-1:0] ref_mag;

    logic [N_CHANNELS-1:0][DATA_SIZE-1:0] err_mag, quo, res;
    logic [N_CHANNELS-1:0]                ovf;
`ifdef MONOPULSE_SIGNED_EN
    logic                  ref_sign;
    logic [N_CHANNELS-1:0] err_sign;
`endif

    assign accept   = i_valid && (state == IDLE);
    assign stepping = (state == DIVIDE);
    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);

    // Most-negative input negates to itself, which reads correctly as 2^(DATA_SIZE-1) unsigned.
    assign ref_mag = i_reference[DATA_SIZE-1] ? -i_reference : i_reference;

    generate
        for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
            logic [DATA_SIZE-1:0] err_raw, mag;
            assign err_raw    = i_error[k*DATA_SIZE +: DATA_SIZE];
            assign err_mag[k] = err_raw[DATA_SIZE-1] ? -err_raw : err_raw;

            monopulse_divider #(.DATA_SIZE(DATA_SIZE), .FRAC_BITS(FRAC_BITS)) u_div (
                .i_clock    (i_clock),
                .i_reset    (i_reset),
                .i_load     (accept),
                .i_step     (stepping),
                .i_dividend (err_mag[k]),
                .i_divisor  (ref_mag),
                .o_quotient (quo[k]),
                .o_overflow (ovf[k])
            );

`ifdef MONOPULSE_SIGNED_EN
            logic neg;
            always_comb begin
                mag = quo[k];
                if (ovf[k] || quo[k][DATA_SIZE-1] || ref_zero) mag = SAT;
                // Zero reference keeps the error's sign; a zero magnitude is always +0.
                neg = (ref_zero ? err_sign[k] : (err_sign[k] ^ ref_sign)) && (mag != '0);
            end
            assign res[k] = neg ? -mag : mag;
`else
            always_comb begin
                mag = quo[k];
                if (ovf[k] || ref_zero) mag = SAT;
            end
            assign res[k] = mag;
`endif
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ref_zero   <= 1'b0;
            o_relation <= '0;
            o_div_zero <= '0;
`ifdef MONOPULSE_SIGNED_EN
            ref_sign   <= 1'b0;
            err_sign   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    state    <= DIVIDE;
                    cnt      <= CW'(ITER - 1);
                    ref_zero <= (i_reference == '0);
`ifdef MONOPULSE_SIGNED_EN
                    ref_sign <= i_reference[DATA_SIZE-1];
                    for (int k = 0; k < N_CHANNELS; k++)
                        err_sign[k] <= i_error[k*DATA_SIZE + DATA_SIZE - 1];
`endif
                end
                DIVIDE: begin
                    if (cnt == '0) begin
                        o_relation <= res;
                        o_div_zero <= {N_CHANNELS{ref_zero}};
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monopulse_ratio.sv
// Directed bench for monopulse_ratio: default 64/16/2 instance plus a 32/8/4 instance.
// Expected values cover both the signed and unsigned builds.
module tb_monopulse_ratio;
    localparam int DS = 64, FB = 16, N = 2, ITER = 80;
    localparam int DS2 = 32, FB2 = 8, N2 = 4, ITER2 = 40;

    logic i_clock = 1'b0;
    always #5 i_clock = ~i_clock;
    logic i_reset;

    logic              a_valid, a_ready, a_ovalid, a_rdy;
    logic [DS-1:0]     a_ref;
    logic [N*DS-1:0]   a_err, a_rel;
    logic [N-1:0]      a_dz;

    logic              b_valid, b_ready, b_ovalid, b_rdy;
    logic [DS2-1:0]    b_ref;
    logic [N2*DS2-1:0] b_err, b_rel;
    logic [N2-1:0]     b_dz;

    monopulse_ratio #(.DATA_SIZE(DS), .FRAC_BITS(FB), .N_CHANNELS(N)) dut_a (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(a_valid), .o_ready(a_ready),
        .i_reference(a_ref), .i_error(a_err), .o_valid(a_ovalid), .i_ready(a_rdy),
        .o_relation(a_rel), .o_div_zero(a_dz));

    monopulse_ratio #(.DATA_SIZE(DS2), .FRAC_BITS(FB2), .N_CHANNELS(N2)) dut_b (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(b_valid), .o_ready(b_ready),
        .i_reference(b_ref), .i_error(b_err), .o_valid(b_ovalid), .i_ready(b_rdy),
        .o_relation(b_rel), .o_div_zero(b_dz));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0]  refv;
        logic [127:0] err;
        logic [127:0] exp_s;
        logic [127:0] exp_u;
        logic [1:0]   dz;
    } vec_t;
    vec_t vecs[8];

    task automatic send_a(input logic [63:0] r, input logic [127:0] e);
        int g = 0;
        while (!a_ready && g < 200) begin @(posedge i_clock); #1; g++; end
        a_ref = r; a_err = e; a_valid = 1'b1;
        @(posedge i_clock); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_ovalid && lat < 200) begin @(posedge i_clock); #1; lat++; end
    endtask

    task automatic consume_a(input string name);
        a_rdy = 1'b1;
        @(posedge i_clock); #1;
        a_rdy = 1'b0;
        check({name, "_valid_drop"}, 256'(a_ovalid), 256'(0));
        check({name, "_ready_back"}, 256'(a_ready), 256'(1));
    endtask

    logic [127:0] expv, held;
    int lat;
    bit stable;

    initial begin
        vecs[0] = '{64'd2, {64'hFFFF_FFFF_FFFF_FFFD, 64'd10},
                    {64'hFFFF_FFFF_FFFE_8000, 64'h5_0000}, {64'h1_8000, 64'h5_0000}, 2'b00};
        vecs[1] = '{64'd0, {64'd0, 64'd7},
                    {64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 2'b11};
        vecs[2] = '{64'd1, {64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF},
                    {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 2'b00};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFB, {64'd5, 64'hFFFF_FFFF_FFFF_FFF6},
                    {64'hFFFF_FFFF_FFFF_0000, 64'h2_0000}, {64'h1_0000, 64'h2_0000}, 2'b00};
        vecs[4] = '{64'd3, {64'd2, 64'd1},
                    {64'hAAAA, 64'h5555}, {64'hAAAA, 64'h5555}, 2'b00};
        vecs[5] = '{64'd0, {64'd0, 64'hFFFF_FFFF_FFFF_FFF9},
                    {64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 2'b11};
        vecs[6] = '{64'h1_0000, {64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF},
                    {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF},
                    {64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF}, 2'b00};
        vecs[7] = '{64'd4, {64'hFFFF_FFFF_FFFF_FFFF, 64'd1},
                    {64'hFFFF_FFFF_FFFF_C000, 64'h4000}, {64'h4000, 64'h4000}, 2'b00};

        i_reset = 1'b1;
        a_valid = 1'b0; a_rdy = 1'b0; a_ref = '0; a_err = '0;
        b_valid = 1'b0; b_rdy = 1'b0; b_ref = '0; b_err = '0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        check("rst_ready", 256'(a_ready), 256'(1));
        check("rst_valid", 256'(a_ovalid), 256'(0));
        check("rst_rel", 256'(a_rel), 256'(0));
        check("rst_dz", 256'(a_dz), 256'(0));
        check("rst_rel_b", 256'(b_rel), 256'(0));

        for (int i = 0; i < 8; i++) begin
`ifdef MONOPULSE_SIGNED_EN
            expv = vecs[i].exp_s;
`else
            expv = vecs[i].exp_u;
`endif
            send_a(vecs[i].refv, vecs[i].err);
            check($sformatf("v%0d_ready_low", i), 256'(a_ready), 256'(0));
            wait_a(lat);
            check($sformatf("v%0d_latency", i), 256'(lat), 256'(ITER));
            check($sformatf("v%0d_rel", i), 256'(a_rel), 256'(expv));
            check($sformatf("v%0d_dz", i), 256'(a_dz), 256'(vecs[i].dz));
            consume_a($sformatf("v%0d", i));
        end

        // Backpressure: results held 20 cycles while a competing sample is offered.
`ifdef MONOPULSE_SIGNED_EN
        expv = vecs[0].exp_s;
`else
        expv = vecs[0].exp_u;
`endif
        send_a(vecs[0].refv, vecs[0].err);
        wait_a(lat);
        held = a_rel;
        check("bp_rel", 256'(held), 256'(expv));
        a_ref = vecs[1].refv; a_err = vecs[1].err; a_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(posedge i_clock); #1;
            if (a_rel !== expv || a_dz !== 2'b00 || a_ready !== 1'b0 || a_ovalid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 256'(stable), 256'(1));
        a_valid = 1'b0;
        consume_a("bp");
        @(posedge i_clock); #1;
        check("bp_second_ignored", 256'(a_ready), 256'(1));
        check("bp_rel_held_idle", 256'(a_rel), 256'(expv));

        // Reset in the middle of a division aborts it.
        send_a(vecs[1].refv, vecs[1].err);
        repeat (39) @(posedge i_clock);
        #1 i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        check("mid_rst_ready", 256'(a_ready), 256'(1));
        check("mid_rst_valid", 256'(a_ovalid), 256'(0));
        check("mid_rst_rel", 256'(a_rel), 256'(0));
        check("mid_rst_dz", 256'(a_dz), 256'(0));
`ifdef MONOPULSE_SIGNED_EN
        expv = vecs[7].exp_s;
`else
        expv = vecs[7].exp_u;
`endif
        send_a(vecs[7].refv, vecs[7].err);
        wait_a(lat);
        check("post_rst_latency", 256'(lat), 256'(ITER));
        check("post_rst_rel", 256'(a_rel), 256'(expv));
        consume_a("post_rst");

        // Narrow 4-channel instance: ref=-3, err={9,-9,0,3}.
        b_ref = 32'hFFFF_FFFD;
        b_err = {32'd3, 32'd0, 32'hFFFF_FFF7, 32'd9};
        b_valid = 1'b1;
        @(posedge i_clock); #1;
        b_valid = 1'b0;
        lat = 0;
        while (!b_ovalid && lat < 200) begin @(posedge i_clock); #1; lat++; end
        check("b_latency", 256'(lat), 256'(ITER2));
`ifdef MONOPULSE_SIGNED_EN
        check("b_rel", 256'(b_rel), 256'({32'hFFFF_FF00, 32'h0, 32'h300, 32'hFFFF_FD00}));
`else
        check("b_rel", 256'(b_rel), 256'({32'h100, 32'h0, 32'h300, 32'h300}));
`endif
        check("b_dz", 256'(b_dz), 256'(0));
        b_rdy = 1'b1;
        @(posedge i_clock); #1;
        b_rdy = 1'b0;
        check("b_ready_back", 256'(b_ready), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
